mul_div_unit: RTL and testbench

Iterative, parametrised multiply/divide unit that owns the HI/LO register pair. It replaces the single-cycle 64-bit multiply path inside the ALU with a shift-add/restoring-divide engine that takes WIDTH+1 cycles per operation. It supports signed and unsigned modes, a start/busy/done handshake for pipeline stalling, divide-by-zero flagging, and direct HI/LO writes for mthi/mtlo.

---
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit.sv | 135 +++++++++++++
 tb/tb_mul_div_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - CPU-side handshake and HI/LO bus of the multiply/divide unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, hi_in, lo_in,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, hi_in, lo_in,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier / restoring divider owning HI/LO
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, qsign_q, rsign_q;
  logic [WIDTH-1:0]   a_mag_q, b_mag_q, a_raw_q;
  logic [WIDTH-1:0]   rem_q, quot_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;
  logic               busy_w;

  logic               sa, sb;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_w = (state_q != IDLE);
  end

  // Operand magnitudes; op[0]=0 selects the signed variants
  always_comb begin
    sa    = ~bus.op[0] & bus.a[WIDTH-1];
    sb    = ~bus.op[0] & bus.b[WIDTH-1];
    a_abs = sa ? -bus.a : bus.a;
    b_abs = sb ? -bus.b : bus.b;
  end

  // rem_q:quot_q is the 2*WIDTH accumulator for multiply and remainder:quotient for divide
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quot_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});
    div_shift = {rem_q, quot_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_mag_q};
    prod      = {rem_q, quot_q};
    prod_fix  = qsign_q ? -prod : prod;
    quo_fix   = qsign_q ? -quot_q : quot_q;
    rem_fix   = rsign_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      a_raw_q  <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q    <= '0;
            is_div_q <= bus.op[1];
            qsign_q  <= sa ^ sb;
            rsign_q  <= sa;
            a_mag_q  <= a_abs;
            b_mag_q  <= b_abs;
            a_raw_q  <= bus.a;
            rem_q    <= '0;
            quot_q   <= bus.op[1] ? a_abs : b_abs;
            dz_q     <= 1'b0;
          end else begin
            if (bus.mthi) hi_q <= bus.hi_in;
            if (bus.mtlo) lo_q <= bus.lo_in;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_q  <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], ~div_trial[WIDTH]};
          end else begin
            rem_q  <= mul_sum[WIDTH:1];
            quot_q <= {mul_sum[0], quot_q[WIDTH-1:1]};
          end
        end
        FIN: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (b_mag_q == '0) begin
            hi_q <= a_raw_q;
            lo_q <= '1;
            dz_q <= 1'b1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_w;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - table-driven and scoreboard bench for mul_div_unit (WIDTH 32 and 8)
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst, rst8;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();
  mul_div_unit_if #(.WIDTH(8))  bus8 ();

  mul_div_unit #(.WIDTH(32)) dut  (.clock(clk), .reset(rst),  .bus(bus.slave));
  mul_div_unit #(.WIDTH(8))  dut8 (.clock(clk), .reset(rst8), .bus(bus8.slave));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done actual=done required=no_done hi=%h lo=%h", bus.hi, bus.lo);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_hi", bus.hi, e.hi);
        chk("sb_lo", bus.lo, e.lo);
        chk("sb_div_zero", bus.div_zero, e.dz);
      end
    end
  end

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    case (op)
      2'd0: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic wait_done(output int cycles, output logic held);
    logic [31:0] h0;
    h0 = bus.hi;
    held = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
      if (!bus.done && bus.hi !== h0) held = 1'b0;
    end while (bus.done !== 1'b1 && cycles < 200);
  endtask

  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_dz_clear", bus.div_zero, 0);
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int   lat;
    logic held;
    launch(op, a, b, e);
    wait_done(lat, held);
    chk("latency", lat, 33);
    chk("hold_during_run", held, 1);
    @(posedge clk); #1;
    chk("done_single_pulse", bus.done, 0);
  endtask

  initial begin
    int   lat;
    logic held;
    exp_t e1;
    vecs[0]  = '{2'd1, 32'd7,          32'd6,          32'h0,          32'h2A,         1'b0};
    vecs[1]  = '{2'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  1'b0};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{2'd3, 32'h1234_5678,  32'd0,          32'h1234_5678,  32'hFFFF_FFFF,  1'b1};
    vecs[4]  = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h1,          1'b0};
    vecs[5]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0};
    vecs[6]  = '{2'd3, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[7]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  1'b0};
    vecs[8]  = '{2'd2, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd3,          1'b0};
    vecs[9]  = '{2'd0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'h0,          1'b0};
    vecs[10] = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  1'b1};
    vecs[11] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h1,          1'b0};
    vecs[12] = '{2'd3, 32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF,  1'b0};
    vecs[13] = '{2'd1, 32'h1234_5678,  32'h10,         32'h1,          32'h2345_6780,  1'b0};

    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.mthi = 0; bus.mtlo = 0; bus.hi_in = 0; bus.lo_in = 0;
    bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0;
    bus8.mthi = 0; bus8.mtlo = 0; bus8.hi_in = 0; bus8.lo_in = 0;
    rst = 1; rst8 = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_dz", bus.div_zero, 0);
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    rst = 0; rst8 = 0;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, '{vecs[i].hi, vecs[i].lo, vecs[i].dz});

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom); a = $urandom; b = (i == 5) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(op, a, b, model(op, a, b));
    end

    // mthi/mtlo while idle, together and singly
    @(negedge clk);
    bus.mthi = 1; bus.mtlo = 1; bus.hi_in = 32'hA5A5_A5A5; bus.lo_in = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    bus.mthi = 0; bus.mtlo = 0;
    chk("mthi_idle", bus.hi, 32'hA5A5_A5A5);
    chk("mtlo_idle", bus.lo, 32'h5A5A_5A5A);
    @(negedge clk);
    bus.mtlo = 1; bus.lo_in = 32'h0000_1234;
    @(posedge clk); #1;
    bus.mtlo = 0;
    chk("mtlo_only_lo", bus.lo, 32'h0000_1234);
    chk("mtlo_only_hi", bus.hi, 32'hA5A5_A5A5);

    // start and mthi in the same idle cycle: mthi dropped
    @(negedge clk);
    bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd2; bus.start = 1; bus.mthi = 1; bus.hi_in = 32'hFFFF;
    sb_q.push_back('{32'h0, 32'h4, 1'b0});
    @(posedge clk); #1;
    bus.start = 0; bus.mthi = 0;
    chk("start_beats_mthi", bus.hi, 32'hA5A5_A5A5);
    wait_done(lat, held);
    chk("start_mthi_latency", lat, 33);

    // second start, mthi and mtlo mid-RUN are ignored
    launch(2'd1, 32'd3, 32'd4, '{32'h0, 32'd12, 1'b0});
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1; bus.op = 2'd0; bus.a = 32'd99; bus.b = 32'd99;
    bus.mthi = 1; bus.mtlo = 1; bus.hi_in = 32'hDEAD; bus.lo_in = 32'hBEEF;
    @(posedge clk); #1;
    bus.start = 0; bus.mthi = 0; bus.mtlo = 0;
    chk("midrun_busy", bus.busy, 1);
    chk("midrun_hi_hold", bus.hi, 32'h0);
    chk("midrun_lo_hold", bus.lo, 32'h4);
    wait_done(lat, held);
    chk("midrun_done_seen", bus.done, 1);
    repeat (40) @(posedge clk);

    // start held on the done cycle launches a back-to-back op
    e1 = '{32'h3, 32'h0, 1'b0};
    launch(2'd1, 32'h0001_0000, 32'h0003_0000, e1);
    wait_done(lat, held);
    chk("b2b_first_latency", lat, 33);
    bus.op = 2'd3; bus.a = 32'd50; bus.b = 32'd8; bus.start = 1;
    sb_q.push_back('{32'd2, 32'd6, 1'b0});
    @(posedge clk); #1;
    bus.start = 0;
    chk("b2b_accept_busy", bus.busy, 1);
    chk("b2b_hi_hold", bus.hi, e1.hi);
    wait_done(lat, held);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_hold_during_run", held, 1);

    // reset mid-RUN cancels the op and clears state
    run_op(2'd3, 32'd77, 32'd0, '{32'd77, 32'hFFFF_FFFF, 1'b1});
    launch(2'd1, 32'd5, 32'd5, '{32'h0, 32'd25, 1'b0});
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    chk("midreset_hi", bus.hi, 0);
    chk("midreset_lo", bus.lo, 0);
    chk("midreset_dz", bus.div_zero, 0);
    sb_q.delete();
    rst = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("midreset_no_busy", bus.busy, 0);

    // WIDTH=8 instance
    @(negedge clk);
    bus8.op = 2'd0; bus8.a = 8'h80; bus8.b = 8'h80; bus8.start = 1;
    @(posedge clk); #1;
    bus8.start = 0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus8.done !== 1'b1 && lat < 50);
    chk("w8_latency", lat, 9);
    chk("w8_mult_hi", bus8.hi, 8'h40);
    chk("w8_mult_lo", bus8.lo, 8'h00);
    @(negedge clk);
    bus8.op = 2'd2; bus8.a = 8'h80; bus8.b = 8'hFF; bus8.start = 1;
    @(posedge clk); #1;
    bus8.start = 0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (bus8.done !== 1'b1 && lat < 50);
    chk("w8_divovf_lo", bus8.lo, 8'h80);
    chk("w8_divovf_hi", bus8.hi, 8'h00);
    @(negedge clk);
    bus8.mthi = 1; bus8.hi_in = 8'hAB;
    @(posedge clk); #1;
    bus8.mthi = 0;
    chk("w8_mthi", bus8.hi, 8'hAB);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
